// File: rtl/three_lane_pkg.sv
// Shared types for the 3-lane output serializer: lane count, lane index and sample/word types.
package three_lane_pkg;
  localparam int LANES    = 3;
  localparam int SAMPLE_W = 16;

  typedef logic [1:0]                 lane_idx_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t                    word_t [LANES];

  localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);
endpackage

// File: rtl/lane_quantizer.sv
// Combinational accumulator -> output sample conversion for one lane.
// SAT_ROUND_EN: round half up and saturate; otherwise truncate and wrap (clipped tied low).
module lane_quantizer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] sample,
  output logic                    clipped
);
  localparam int EW = IN_W + 1;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] t;

`ifdef SAT_ROUND_EN
  // one extra bit so the rounding add cannot wrap at the top of the range
  if (SHIFT > 0) begin : g_rnd
    assign ext = {din[IN_W-1], din} + (EW'(1) << (SHIFT - 1));
  end else begin : g_nornd
    assign ext = {din[IN_W-1], din};
  end
  assign t = ext >>> SHIFT;

  // in range iff every bit from the output sign bit upward matches
  assign clipped = !((&t[EW-1:OUT_W-1]) || !(|t[EW-1:OUT_W-1]));
  assign sample  = !clipped  ? t[OUT_W-1:0] :
                   t[EW-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                               {1'b0, {(OUT_W-1){1'b1}}};
`else
  logic unused_hi;
  assign ext       = {din[IN_W-1], din};
  assign t         = ext >>> SHIFT;
  assign sample    = t[OUT_W-1:0];
  assign clipped   = 1'b0;
  assign unused_hi = ^t[EW-1:OUT_W];
`endif
endmodule

// File: rtl/three_lane_serializer.sv
// Re-serialises 3-lane filter words into one quantised sample per cycle through a 2-word FIFO.
// SAT_ROUND_EN selects rounding/saturation in the lane quantizers and enables sat_flag.
module three_lane_serializer
  import three_lane_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  din0,
  input  logic signed [IN_W-1:0]  din1,
  input  logic signed [IN_W-1:0]  din2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output lane_idx_t               out_lane,
  output logic                    out_last,
  output logic                    sat_flag
);
  logic [LANES-1:0][IN_W-1:0]  din_v;
  logic [LANES-1:0][OUT_W-1:0] q;
  logic [LANES-1:0]            clip;

  logic [1:0][LANES-1:0][OUT_W-1:0] mem;
  logic [1:0] count;
  lane_idx_t  lane;
  logic       wr_ptr, rd_ptr;
  logic       sat_q;
  logic       accept, emit, pop;

  assign din_v = {din2, din1, din0};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_quantizer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_q (
      .din     (din_v[i]),
      .sample  (q[i]),
      .clipped (clip[i])
    );
  end

  // gated by reset so nothing looks ready while the block is held
  assign in_ready  = rst && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign dout      = mem[rd_ptr][lane];
  assign out_lane  = lane;
  assign out_last  = (lane == LAST_LANE);
  assign sat_flag  = sat_q;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;
  assign pop    = emit && (lane == LAST_LANE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      count  <= '0;
      lane   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= q;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (emit) lane <= pop ? lane_idx_t'(0) : lane + lane_idx_t'(1);
      count <= count + 2'(accept) - 2'(pop);
      sat_q <= sat_q | (accept & (|clip));
    end
  end
endmodule

// File: tb/tb_three_lane_serializer.sv
// Directed self-checking bench for three_lane_serializer; expectations follow SAT_ROUND_EN.
module tb_three_lane_serializer;
  import three_lane_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic signed [63:0] din0, din1, din2;
  logic              out_valid, out_ready;
  logic signed [15:0] dout;
  lane_idx_t         out_lane;
  logic              out_last, sat_flag;

  int checks = 0;
  int errors = 0;

`ifdef SAT_ROUND_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  three_lane_serializer #(.IN_W(64), .OUT_W(16), .SHIFT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .din2(din2),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_lane(out_lane), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input longint a, input longint b, input longint c);
    din0 = a; din1 = b; din2 = c;
  endtask

  initial begin
    int got, cyc;
    bit acc;

    // reset held with a word offered
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    set_word(64'sd32768, 64'sd65536, 64'sd98304);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_dout",      dout,      0);
    chk("rst_lane",      out_lane,  0);
    chk("rst_last",      out_last,  0);
    chk("rst_sat",       sat_flag,  0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready",  in_ready,  1);
    chk("rel_out_valid", out_valid, 0);

    // order / latency
    out_ready = 1'b1;
    set_word(64'sd32768, 64'sd65536, -64'sd32768);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("ord_valid0", out_valid, 1);
    chk("ord_dout0",  dout, 1);
    chk("ord_lane0",  out_lane, 0);
    chk("ord_last0",  out_last, 0);
    tick();
    chk("ord_dout1",  dout, 2);
    chk("ord_lane1",  out_lane, 1);
    chk("ord_last1",  out_last, 0);
    tick();
    chk("ord_dout2",  dout, -1);
    chk("ord_lane2",  out_lane, 2);
    chk("ord_last2",  out_last, 1);
    tick();
    chk("ord_empty",  out_valid, 0);

    // backpressure: two words fill the FIFO, third waits
    out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      set_word((3*w+1)*32768, (3*w+2)*32768, (3*w+3)*32768);
      in_valid = 1'b1;
      chk("bp_in_ready", in_ready, (w < 2) ? 1 : 0);
      if (w < 2) tick();
    end
    chk("bp_hold_lane", out_lane, 0);
    out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 9 && cyc < 40) begin
      if (out_valid) begin
        chk("bp_dout", dout, got + 1);
        chk("bp_lane", out_lane, got % 3);
        got++;
      end
      acc = in_valid && in_ready;
      tick(); cyc++;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_samples", got, 9);
    chk("bp_cycles",  cyc, 9);
    chk("bp_empty",   out_valid, 0);

    // hold under stall
    set_word(64'sd32768, 64'sd65536, 64'sd98304);
    in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    chk("hold_dout0", dout, 1);
    tick();
    chk("hold_dout1", dout, 2);
    out_ready = 1'b0;
    tick();
    chk("hold_stall_a", dout, 2);
    chk("hold_lane_a",  out_lane, 1);
    tick();
    chk("hold_stall_b", dout, 2);
    chk("hold_lane_b",  out_lane, 1);
    out_ready = 1'b1;
    tick();
    chk("hold_dout2", dout, 3);
    chk("hold_last",  out_last, 1);
    tick();
    chk("hold_empty", out_valid, 0);

    // quantise and saturate
    chk("pre_sat", sat_flag, 0);
    set_word(64'sd49152, 64'sd1 <<< 40, -(64'sd1 <<< 40));
    in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    chk("q_round", dout, SAT ? 2 : 1);
    chk("q_sat_flag", sat_flag, SAT ? 1 : 0);
    tick();
    chk("q_pos_clip", dout, SAT ? 32767 : 0);
    tick();
    chk("q_neg_clip", dout, SAT ? -32768 : 0);
    tick();
    chk("q_sat_sticky", sat_flag, SAT ? 1 : 0);

    // reset mid-word discards data
    set_word(64'sd32768, 64'sd65536, 64'sd98304);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    chk("mid_lane_pre", out_lane, 1);
    rst = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_dout",  dout, 0);
    chk("mid_lane",  out_lane, 0);
    chk("mid_sat",   sat_flag, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_after_valid", out_valid, 0);
    chk("mid_after_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
